// File: rtl/qos_fsm_pkg.sv
// rtl/qos_fsm_pkg.sv - shared state codes, widths and helpers for the QoS flow FSM
//
// Purpose: state encoding, error-counter width and the idle-counter width
//          helper used by qos_flow_fsm.
// Ports:   none (package).

package qos_fsm_pkg;

  localparam int STATE_W   = 3;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // Width needed to hold the values 0..hold inclusive.
  function automatic int idle_cnt_w(input int hold);
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/qos_edge_det.sv
// rtl/qos_edge_det.sv - per-bit rising-edge detector with registered history
//
// Purpose: keeps last cycle's value of a request vector and flags bits that
//          are high now but were low on the previous cycle.
// Ports:
//   CLK      in   clock
//   reset_L  in   asynchronous active-low reset (clears history)
//   din      in   WIDTH request levels
//   rise     out  WIDTH rising-edge flags (combinational from din and history)

module qos_edge_det #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] hist;

  always_ff @(posedge CLK or negedge reset_L) begin
    if (!reset_L) begin
      hist <= '0;
    end else begin
      hist <= din;
    end
  end

  assign rise = din & ~hist;

endmodule

// File: rtl/qos_flow_fsm.sv
// rtl/qos_flow_fsm.sv - QoS control FSM sequencing NUM_CH egress FIFOs
//
// Purpose: sequences RESET/INIT/IDLE/ACTIVE/ERROR, raises one-cycle
//          pause/continue strobes on fresh request edges while ACTIVE,
//          drains back to IDLE after IDLE_HOLD all-empty cycles and keeps a
//          sticky record of FIFOs seen full while in ERROR.
// Optional: define QOS_FSM_ERR_CNT_EN to add err_cnt, one saturating 8-bit
//          counter of full[i] rising edges per channel.
// Ports:
//   CLK             in   clock
//   reset_L         in   asynchronous active-low reset
//   set_init        in   level, holds the block in INIT
//   clear_err       in   pulse, leaves ERROR
//   empty/full      in   NUM_CH per-FIFO flags
//   pause_fifos     in   NUM_CH pause request levels
//   continue_fifos  in   NUM_CH continue request levels
//   init/idle/active out  registered state indicators
//   state_o         out  current state code
//   pause_stb       out  NUM_CH one-cycle pause strobes
//   continue_stb    out  NUM_CH one-cycle continue strobes
//   error_full      out  NUM_CH sticky full record, valid in ERROR only
//   err_cnt         out  NUM_CH*8 full-edge counters (QOS_FSM_ERR_CNT_EN only)

module qos_flow_fsm
  import qos_fsm_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int IDLE_HOLD = 4
) (
  input  logic                    CLK,
  input  logic                    reset_L,
  input  logic                    set_init,
  input  logic                    clear_err,
  input  logic [NUM_CH-1:0]       empty,
  input  logic [NUM_CH-1:0]       full,
  input  logic [NUM_CH-1:0]       pause_fifos,
  input  logic [NUM_CH-1:0]       continue_fifos,
  output logic                    init,
  output logic                    idle,
  output logic                    active,
  output logic [STATE_W-1:0]      state_o,
  output logic [NUM_CH-1:0]       pause_stb,
  output logic [NUM_CH-1:0]       continue_stb,
  output logic [NUM_CH-1:0]       error_full
`ifdef QOS_FSM_ERR_CNT_EN
  ,
  output logic [NUM_CH*ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int               CNT_W    = idle_cnt_w(IDLE_HOLD);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(IDLE_HOLD);

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              all_empty;
  logic [NUM_CH-1:0] pause_rise;
  logic [NUM_CH-1:0] cont_rise;

  assign all_empty = &empty;
  assign state_o   = state_q;

  qos_edge_det #(.WIDTH(NUM_CH)) u_pause_edge (
    .CLK     (CLK),
    .reset_L (reset_L),
    .din     (pause_fifos),
    .rise    (pause_rise)
  );

  qos_edge_det #(.WIDTH(NUM_CH)) u_cont_edge (
    .CLK     (CLK),
    .reset_L (reset_L),
    .din     (continue_fifos),
    .rise    (cont_rise)
  );

  // Count of consecutive all-empty cycles including the current one; a
  // non-empty cycle restarts the run.
  always_comb begin
    cnt_d = '0;
    if (all_empty) begin
      cnt_d = (cnt_q >= HOLD_MAX) ? HOLD_MAX : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = set_init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (set_init)        state_d = ST_INIT;
        else if (!all_empty) state_d = ST_ACTIVE;
        else                 state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (set_init)               state_d = ST_INIT;
        else if (|full)             state_d = ST_ERROR;
        else if (cnt_d == HOLD_MAX) state_d = ST_IDLE;
        else                        state_d = ST_ACTIVE;
      end
      // set_init has no effect here; only clear_err leaves ERROR.
      ST_ERROR:  state_d = clear_err ? ST_INIT : ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state being entered on this edge.
  always_ff @(posedge CLK or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      init         <= 1'b0;
      idle         <= 1'b0;
      active       <= 1'b0;
      pause_stb    <= '0;
      continue_stb <= '0;
      error_full   <= '0;
    end else begin
      state_q <= state_d;
      init    <= (state_d == ST_INIT) && set_init;
      idle    <= (state_d == ST_IDLE);
      active  <= (state_d == ST_ACTIVE);
      cnt_q   <= (state_q == ST_ACTIVE) ? cnt_d : '0;

      // Pause wins a same-channel tie with continue.
      if (state_d == ST_ACTIVE) begin
        pause_stb    <= pause_rise;
        continue_stb <= cont_rise & ~pause_rise;
      end else begin
        pause_stb    <= '0;
        continue_stb <= '0;
      end

      if (state_d == ST_ERROR) begin
        error_full <= (state_q == ST_ERROR) ? (error_full | full) : full;
      end else begin
        error_full <= '0;
      end
    end
  end

`ifdef QOS_FSM_ERR_CNT_EN
  logic [NUM_CH-1:0] full_hist;

  always_ff @(posedge CLK or negedge reset_L) begin
    if (!reset_L) begin
      full_hist <= '0;
      err_cnt   <= '0;
    end else begin
      full_hist <= full;
      for (int i = 0; i < NUM_CH; i++) begin
        if ((state_q == ST_ERROR) && clear_err) begin
          err_cnt[i*ERR_CNT_W +: ERR_CNT_W] <= '0;
        end else if ((state_q != ST_RESET) && full[i] && !full_hist[i] &&
                     (err_cnt[i*ERR_CNT_W +: ERR_CNT_W] != {ERR_CNT_W{1'b1}})) begin
          err_cnt[i*ERR_CNT_W +: ERR_CNT_W] <= err_cnt[i*ERR_CNT_W +: ERR_CNT_W] + ERR_CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_qos_flow_fsm.sv
// tb/tb_qos_flow_fsm.sv - self-checking bench for qos_flow_fsm

module tb_qos_flow_fsm;

  localparam int N  = 4;
  localparam int H  = 4;
  localparam int BW = 6 + 3 * N;

  logic         CLK            = 1'b0;
  logic         reset_L        = 1'b0;
  logic         set_init       = 1'b0;
  logic         clear_err      = 1'b0;
  logic [N-1:0] empty          = '1;
  logic [N-1:0] full           = '0;
  logic [N-1:0] pause_fifos    = '0;
  logic [N-1:0] continue_fifos = '0;

  logic         init;
  logic         idle;
  logic         active;
  logic [2:0]   state_o;
  logic [N-1:0] pause_stb;
  logic [N-1:0] continue_stb;
  logic [N-1:0] error_full;

  qos_flow_fsm #(.NUM_CH(N), .IDLE_HOLD(H)) dut (
    .CLK            (CLK),
    .reset_L        (reset_L),
    .set_init       (set_init),
    .clear_err      (clear_err),
    .empty          (empty),
    .full           (full),
    .pause_fifos    (pause_fifos),
    .continue_fifos (continue_fifos),
    .init           (init),
    .idle           (idle),
    .active         (active),
    .state_o        (state_o),
    .pause_stb      (pause_stb),
    .continue_stb   (continue_stb),
    .error_full     (error_full)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state as plain integers, drain run as an unbounded count.
  int           m_state;
  int           m_run;
  logic [N-1:0] m_pprev;
  logic [N-1:0] m_cprev;
  logic [N-1:0] m_ef;

  logic         e_init;
  logic         e_idle;
  logic         e_active;
  logic [2:0]   e_state;
  logic [N-1:0] e_pstb;
  logic [N-1:0] e_cstb;
  logic [N-1:0] e_ef;

  wire [BW-1:0] dut_bus = {init, idle, active, state_o, pause_stb, continue_stb, error_full};
  wire [BW-1:0] exp_bus = {e_init, e_idle, e_active, e_state, e_pstb, e_cstb, e_ef};

  task automatic model_reset();
    m_state  = 0;
    m_run    = 0;
    m_pprev  = '0;
    m_cprev  = '0;
    m_ef     = '0;
    e_init   = 1'b0;
    e_idle   = 1'b0;
    e_active = 1'b0;
    e_state  = 3'd0;
    e_pstb   = '0;
    e_cstb   = '0;
    e_ef     = '0;
  endtask

  task automatic model_step();
    int ns;
    int run;
    bit all_e;
    bit pr;
    bit cr;
    all_e = (empty == {N{1'b1}});
    run   = (m_state == 3 && all_e) ? m_run + 1 : 0;
    if (m_state == 0)                    ns = 1;
    else if (m_state != 4 && set_init)   ns = 1;
    else if (m_state == 1)               ns = 2;
    else if (m_state == 2)               ns = all_e ? 2 : 3;
    else if (m_state == 3)               ns = (full != 0) ? 4 : ((run >= H) ? 2 : 3);
    else                                 ns = clear_err ? 1 : 4;
    for (int i = 0; i < N; i++) begin
      pr        = pause_fifos[i] && !m_pprev[i];
      cr        = continue_fifos[i] && !m_cprev[i];
      e_pstb[i] = (ns == 3) && pr;
      e_cstb[i] = (ns == 3) && cr && !pr;
    end
    e_ef     = (ns == 4) ? ((m_state == 4) ? (m_ef | full) : full) : '0;
    e_init   = (ns == 1) && set_init;
    e_idle   = (ns == 2);
    e_active = (ns == 3);
    e_state  = 3'(ns);
    m_ef     = e_ef;
    m_run    = run;
    m_pprev  = pause_fifos;
    m_cprev  = continue_fifos;
    m_state  = ns;
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    n_checks++; if (dut_bus !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", dut_bus); end
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    reset_L = 1'b1;
  endtask

  task automatic test_bringup();
    set_init = 1'b1;
    empty    = '1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (init !== 1'b1 || state_o !== 3'd1) begin n_fail++; $display("FAIL bringup_init%0d: got init=%b state=%0d expected init=1 state=1", k, init, state_o); end
      n_checks++; if (dut_bus !== exp_bus) begin n_fail++; $display("FAIL bringup_bus%0d: got %h expected %h", k, dut_bus, exp_bus); end
    end
    set_init = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if (idle !== 1'b1 || init !== 1'b0 || state_o !== 3'd2) begin n_fail++; $display("FAIL bringup_idle%0d: got idle=%b init=%b state=%0d expected 1 0 2", k, idle, init, state_o); end
    end
  endtask

  task automatic test_pause_edge();
    empty = 4'b1110;
    step();
    n_checks++; if (active !== 1'b1 || state_o !== 3'd3) begin n_fail++; $display("FAIL pause_enter_active: got active=%b state=%0d expected 1 3", active, state_o); end
    pause_fifos = 4'b0100;
    step();
    n_checks++; if (pause_stb !== 4'b0100) begin n_fail++; $display("FAIL pause_strobe: got %b expected 0100", pause_stb); end
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if (pause_stb !== 4'b0000) begin n_fail++; $display("FAIL pause_hold%0d: got %b expected 0000", k, pause_stb); end
      n_checks++; if (dut_bus !== exp_bus) begin n_fail++; $display("FAIL pause_bus%0d: got %h expected %h", k, dut_bus, exp_bus); end
    end
  endtask

  task automatic test_conflict();
    pause_fifos    = 4'b0000;
    continue_fifos = 4'b0000;
    step();
    pause_fifos    = 4'b0010;
    continue_fifos = 4'b0010;
    step();
    n_checks++; if (pause_stb !== 4'b0010 || continue_stb !== 4'b0000) begin n_fail++; $display("FAIL conflict_same_ch: got p=%b c=%b expected p=0010 c=0000", pause_stb, continue_stb); end
    pause_fifos    = 4'b0011;
    continue_fifos = 4'b1010;
    step();
    n_checks++; if (pause_stb !== 4'b0001 || continue_stb !== 4'b1000) begin n_fail++; $display("FAIL conflict_indep: got p=%b c=%b expected p=0001 c=1000", pause_stb, continue_stb); end
    n_checks++; if (dut_bus !== exp_bus) begin n_fail++; $display("FAIL conflict_bus: got %h expected %h", dut_bus, exp_bus); end
  endtask

  task automatic test_error();
    full        = 4'b0001;
    pause_fifos = 4'b0111;
    step();
    n_checks++; if (state_o !== 3'd4 || error_full !== 4'b0001 || pause_stb !== 4'b0000) begin n_fail++; $display("FAIL error_entry: got state=%0d ef=%b p=%b expected 4 0001 0000", state_o, error_full, pause_stb); end
    full = 4'b1000;
    step();
    n_checks++; if (error_full !== 4'b1001) begin n_fail++; $display("FAIL error_accum: got %b expected 1001", error_full); end
    full     = 4'b0000;
    set_init = 1'b1;
    step();
    n_checks++; if (state_o !== 3'd4 || error_full !== 4'b1001) begin n_fail++; $display("FAIL error_ignore_init: got state=%0d ef=%b expected 4 1001", state_o, error_full); end
    clear_err = 1'b1;
    step();
    n_checks++; if (state_o !== 3'd1 || error_full !== 4'b0000 || init !== 1'b1) begin n_fail++; $display("FAIL error_clear: got state=%0d ef=%b init=%b expected 1 0000 1", state_o, error_full, init); end
    clear_err = 1'b0;
    set_init  = 1'b0;
    empty     = '1;
    step();
    n_checks++; if (dut_bus !== exp_bus || state_o !== 3'd2) begin n_fail++; $display("FAIL error_to_idle: got %h expected %h", dut_bus, exp_bus); end
  endtask

  task automatic test_drain_hold();
    empty = 4'b1110;
    step();
    empty = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL drain_first%0d: got %0d expected 3", k, state_o); end
    end
    empty = 4'b0111;
    step();
    n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL drain_break: got %0d expected 3", state_o); end
    empty = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k < 3) begin
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL drain_hold%0d: got %0d expected 3", k, state_o); end
      end else begin
        n_checks++; if (state_o !== 3'd2 || idle !== 1'b1) begin n_fail++; $display("FAIL drain_exit: got state=%0d idle=%b expected 2 1", state_o, idle); end
      end
    end
  endtask

  task automatic test_held_before_active();
    pause_fifos    = 4'b1111;
    continue_fifos = 4'b1111;
    step();
    step();
    empty = 4'b1101;
    step();
    n_checks++; if (state_o !== 3'd3 || pause_stb !== 4'b0000 || continue_stb !== 4'b0000) begin n_fail++; $display("FAIL held_no_strobe: got state=%0d p=%b c=%b expected 3 0000 0000", state_o, pause_stb, continue_stb); end
    n_checks++; if (dut_bus !== exp_bus) begin n_fail++; $display("FAIL held_bus: got %h expected %h", dut_bus, exp_bus); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      set_init       = ($urandom_range(0, 19) == 0);
      clear_err      = ($urandom_range(0, 5) == 0);
      empty          = ($urandom_range(0, 2) == 0) ? N'($urandom) : '1;
      full           = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      pause_fifos    = ($urandom_range(0, 1) == 0) ? N'($urandom) : pause_fifos;
      continue_fifos = ($urandom_range(0, 1) == 0) ? N'($urandom) : continue_fifos;
      step();
      n_checks++; if (dut_bus !== exp_bus) begin n_fail++; $display("FAIL random_cyc%0d: got %h expected %h (state %0d exp %0d)", k, dut_bus, exp_bus, state_o, e_state); end
    end
  endtask

  task automatic test_async_reset();
    reset_L = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    reset_L        = 1'b1;
    set_init       = 1'b0;
    clear_err      = 1'b0;
    empty          = '1;
    full           = '0;
    pause_fifos    = '0;
    continue_fifos = '0;
    step();
    n_checks++; if (state_o !== 3'd1 || init !== 1'b0) begin n_fail++; $display("FAIL async_init_noset: got state=%0d init=%b expected 1 0", state_o, init); end
    step();
    empty = 4'b1110;
    step();
    pause_fifos = 4'b0010;
    step();
    n_checks++; if (pause_stb !== 4'b0010 || state_o !== 3'd3) begin n_fail++; $display("FAIL async_pending_stb: got p=%b state=%0d expected 0010 3", pause_stb, state_o); end
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    n_checks++; if (dut_bus !== '0 || state_o !== 3'd0) begin n_fail++; $display("FAIL async_clear: got %h state=%0d expected 0 0", dut_bus, state_o); end
    @(posedge CLK);
    #1;
    reset_L = 1'b1;
    step();
    n_checks++; if (dut_bus !== exp_bus || state_o !== 3'd1) begin n_fail++; $display("FAIL async_restart: got %h expected %h", dut_bus, exp_bus); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_pause_edge();
    test_conflict();
    test_error();
    test_drain_hold();
    test_held_before_active();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
